// File: rtl/lsu_mem_port.sv
// ----------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store port between the MEM stage and data memory. One load or store is
// accepted per instruction, presented to memory over a valid/ready request,
// and completed by a response (load data or store ack), a response timeout,
// or (optionally) a misalignment trap. The pipeline is stalled until the
// access completes; completion is signalled by a one-cycle done pulse.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip memory and complete with
//               misalign=1 (no store write, ld_data unchanged).
//   undefined : misalign is tied 0; halves ignore addr[0], words ignore
//               addr[1:0] (access aligned down).
//
// Parameters
//   RSP_TIMEOUT   cycles waited in RSP before declaring a bus error (1..65535)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid         MEM stage holds a load/store (stable while stall=1)
//   req_we            1 = store, 0 = load
//   req_func3         RV32I funct3: [1:0] size, [2] passed through
//   req_addr          byte address
//   req_wdata         store value (rs2)
//   stall             freeze pipeline
//   done              one-cycle completion pulse
//   ld_data           loaded lane right-justified to bit 0
//   ld_func3          latched funct3 for the extension filter
//   bus_err           response timeout, valid with done
//   misalign          misaligned-access trap, valid with done
//   mem_req_valid     request valid        / mem_req_ready  request accepted
//   mem_we, mem_addr, mem_wstrb, mem_wdata request fields (word-aligned addr)
//   mem_rsp_valid     response valid       / mem_rsp_data   response word
// ----------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic [2:0]  ld_func3,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam logic [15:0] TMO_LIMIT = 16'(RSP_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [2:0]  func3_r;
    logic [1:0]  lo_r;
    logic [15:0] tmo_cnt_r;
    logic        tmo_hit_s;
    logic        trap_s;

    logic        stall_s;
    logic        done_s;
    logic        mem_req_valid_s;

    logic [31:0] ld_data_r;
    logic [2:0]  ld_func3_r;
    logic        bus_err_r;
    logic        misalign_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_wstrb_r;
    logic [31:0] mem_wdata_r;

    // Byte strobes for a store of the given size at the given lane offset.
    function automatic logic [3:0] build_wstrb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Store data replicated across all lanes so any strobe picks the right bytes.
    function automatic logic [31:0] build_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Shift the addressed lane of the response word down to bit 0.
    function automatic logic [31:0] align_load(input logic [1:0] size, input logic [1:0] lo,
                                               input logic [31:0] data);
        logic [31:0] d;
        case (size)
            2'b00:   d = data >> {lo, 3'b000};
            2'b01:   d = data >> {lo[1], 4'b0000};
            default: d = data;
        endcase
        return d;
    endfunction

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lo[0];
            default: m = (lo != 2'b00);
        endcase
        return m;
    endfunction

    assign trap_s = is_misaligned(req_func3[1:0], req_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    assign tmo_hit_s = (tmo_cnt_r == TMO_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a response wins over a timeout in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = trap_s ? ST_DONE : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_nxt_s = mem_req_ready ? ST_RSP : ST_REQ;
            end
            ST_RSP: begin
                if (mem_rsp_valid || tmo_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded control outputs; in IDLE the stall follows req_valid so
    // the accepting cycle is already frozen.
    always_comb begin
        stall_s         = 1'b0;
        done_s          = 1'b0;
        mem_req_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = req_valid;
            end
            ST_REQ: begin
                stall_s         = 1'b1;
                mem_req_valid_s = 1'b1;
            end
            ST_RSP: begin
                stall_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Datapath: request latching, response capture, timeout counter and the
    // one-cycle completion flags (set on entry to DONE, cleared otherwise).
    always_ff @(posedge clk) begin
        if (rst) begin
            func3_r     <= 3'd0;
            lo_r        <= 2'd0;
            tmo_cnt_r   <= 16'd0;
            ld_data_r   <= 32'd0;
            ld_func3_r  <= 3'd0;
            bus_err_r   <= 1'b0;
            misalign_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wstrb_r <= 4'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            bus_err_r  <= 1'b0;
            misalign_r <= 1'b0;

            // Counter is zero on the first RSP cycle and counts RSP cycles.
            if (state_r == ST_RSP) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end else begin
                tmo_cnt_r <= 16'd0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        func3_r <= req_func3;
                        lo_r    <= req_addr[1:0];
                        if (trap_s) begin
                            // Memory fields left untouched: nothing is issued.
                            misalign_r <= 1'b1;
                            ld_func3_r <= req_func3;
                        end else begin
                            mem_we_r    <= req_we;
                            mem_addr_r  <= {req_addr[31:2], 2'b00};
                            mem_wstrb_r <= req_we ? build_wstrb(req_func3[1:0], req_addr[1:0]) : 4'b0000;
                            mem_wdata_r <= req_we ? build_wdata(req_func3[1:0], req_wdata) : 32'd0;
                        end
                    end
                end
                ST_RSP: begin
                    if (mem_rsp_valid) begin
                        ld_data_r  <= align_load(func3_r[1:0], lo_r, mem_rsp_data);
                        ld_func3_r <= func3_r;
                    end else if (tmo_hit_s) begin
                        ld_data_r  <= 32'd0;
                        ld_func3_r <= func3_r;
                        bus_err_r  <= 1'b1;
                    end
                end
                default: begin
                    lo_r <= lo_r;
                end
            endcase
        end
    end

    assign stall         = stall_s;
    assign done          = done_s;
    assign mem_req_valid = mem_req_valid_s;
    assign ld_data       = ld_data_r;
    assign ld_func3      = ld_func3_r;
    assign bus_err       = bus_err_r;
    assign misalign      = misalign_r;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wstrb     = mem_wstrb_r;
    assign mem_wdata     = mem_wdata_r;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store memory port between the MEM stage and data memory. Accepts one load or store per instruction, drives a valid/ready request to data memory, builds byte strobes and lane-replicated store data, and returns load data right-justified to bit 0 for the downstream load sign/zero-extension filter. Stalls the pipeline until the access completes, times out, or faults.

## Interface
- RSP_TIMEOUT, 255: max cycles waited in RSP before declaring a bus error (1..65535)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage holds a load/store; held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_func3  in  3  RV32I funct3: size in [1:0] (00 byte, 01 half, 1x word); [2] passed through
- req_addr  in  32  byte address
- req_wdata  in  32  rs2 store value
- stall  out  1  freeze pipeline
- done  out  1  one-cycle completion pulse
- ld_data  out  32  loaded lane shifted to bit 0, upper bits unmodified raw word bits
- ld_func3  out  3  latched req_func3, for the extension filter
- bus_err  out  1  timeout flag, valid with done
- misalign  out  1  misaligned-access flag, valid with done (0 unless MISALIGN_TRAP_EN)
- mem_req_valid  out  1 / mem_req_ready  in  1  request handshake
- mem_we  out  1, mem_addr  out  32 (bits [1:0]=0), mem_wstrb  out  4, mem_wdata  out  32
- mem_rsp_valid  in  1 / mem_rsp_data  in  32  response (loads and store acks)

## Operation
- States IDLE, REQ, RSP, DONE. Reset: IDLE; all outputs 0.
- IDLE: req_valid=1 latches we/func3/addr/wdata; -> REQ (or DONE on trap). stall = req_valid.
- REQ: mem_req_valid=1, fields stable until mem_req_ready=1; -> RSP.
- RSP: timeout counter cleared on entry, increments each cycle; mem_rsp_valid=1 -> DONE, capture data; counter reaches RSP_TIMEOUT first -> DONE with bus_err=1, ld_data=0.
- DONE: done=1, stall=0, flags valid one cycle; -> IDLE. req_valid in following IDLE is a new instruction.
- mem_rsp_valid ignored outside RSP.
- Strobes/data: byte: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; half: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; word: 4'b1111, wdata unchanged. Loads: mem_wstrb=0.
- Load align: byte: rsp>>(8*addr[1:0]); half: rsp>>(16*addr[1]); word: rsp.
- ld_data, ld_func3 hold value from DONE until next DONE.
- Reset mid-operation: immediate return to IDLE, in-flight response discarded.

## Timing
- Zero-wait memory (ready=1 in REQ, rsp_valid on first RSP cycle): cycle 0 IDLE accept, 1 REQ, 2 RSP, 3 DONE; stall high cycles 0-2, done cycle 3.
- Each cycle of ready=0 or rsp_valid=0 adds one stall cycle.
- Timeout: DONE arrives RSP_TIMEOUT+1 cycles after RSP entry.
- No combinational path from mem_rsp_* to ld_data or stall.

## Configuration
- MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 skips memory, IDLE -> DONE, misalign=1, ld_data unchanged, no store write.
- Undefined: misalign tied 0; half ignores addr[0], word ignores addr[1:0] (access aligned down).

## Test plan
- Store byte 0xA5 to 0x1003, zero-wait -> mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, done at cycle 3.
- Load half from 0x2002, rsp_data=0x8001_7FFF, ready low 2 cycles -> ld_data[15:0]=0x8001, ld_func3 echoed, stall 5 cycles.
- Load word, rsp never returns, RSP_TIMEOUT=4 -> done with bus_err=1, ld_data=0, 5 cycles after RSP entry.
- Word load from 0x3001: with MISALIGN_TRAP_EN -> no mem_req_valid, done+misalign next cycle; without -> mem_addr=0x3000.
- rst asserted during RSP, then rsp_valid arrives -> stays IDLE, outputs 0, no done.
- Back-to-back store then load, zero-wait -> two done pulses 4 cycles apart, one IDLE cycle between.
